// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution streaming front end.
package conv_pkg;

    localparam int unsigned BIT_WIDTH_DEF = 8;
    localparam int unsigned MAP_SIZE_DEF  = 32;
    localparam int unsigned WIN_SIZE      = 5;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

endpackage

// File: rtl/win_delay_pipe.sv
// Fixed-depth shift register that carries {valid,row,col} of a window alongside
// the window engine's arithmetic latency.
module win_delay_pipe #(
    parameter int unsigned COORD_W = 5,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    output logic               o_valid,
    output logic [COORD_W-1:0] o_row,
    output logic [COORD_W-1:0] o_col
);

    localparam int unsigned W = 1 + 2 * COORD_W;

    logic [W-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= {i_valid, i_row, i_col};
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {o_valid, o_row, o_col} = r_pipe[DEPTH-1];

endmodule

// File: rtl/conv_streamer.sv
// Streams one MAP_SIZE x MAP_SIZE map from memory into a 5x5 window engine in raster
// order and flags the engine results that belong to fully-inside windows.
module conv_streamer
    import conv_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = BIT_WIDTH_DEF,
    parameter int unsigned MAP_SIZE   = MAP_SIZE_DEF,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MULT_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    output logic                        mem_rd,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [BIT_WIDTH-1:0]        mem_data,
    output logic [BIT_WIDTH-1:0]        next,
    output logic                        shift_en_n,
    output logic                        win_valid,
    output logic [$clog2(MAP_SIZE)-1:0] win_row,
    output logic [$clog2(MAP_SIZE)-1:0] win_col,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned   CW         = $clog2(MAP_SIZE);
    localparam int unsigned   PIPE_DEPTH = MULT_LAT + 3;
    localparam logic [CW-1:0] LAST_IDX   = CW'(MAP_SIZE - 1);
    localparam logic [CW-1:0] EDGE_IDX   = CW'(WIN_SIZE - 1);
    // DRAIN lasts PIPE_DEPTH+1 cycles; the final one carries done.
    localparam logic [2:0]    DRAIN_LAST = 3'(PIPE_DEPTH);

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_row, r_col;
    logic [2:0]            r_drain;
    logic                  r_rd_d1;
    logic                  r_shift_n;
    logic [BIT_WIDTH-1:0]  r_next;

    logic                  w_reading, w_last_pix, w_drain_end, w_in_valid;
    logic [CW-1:0]         w_in_row, w_in_col;

    assign w_reading   = (r_state == STREAM);
    assign w_last_pix  = (r_row == LAST_IDX) && (r_col == LAST_IDX);
    assign w_drain_end = (r_drain == DRAIN_LAST);
    assign w_in_valid  = w_reading && (r_row >= EDGE_IDX) && (r_col >= EDGE_IDX);
    assign w_in_row    = w_in_valid ? r_row - EDGE_IDX : '0;
    assign w_in_col    = w_in_valid ? r_col - EDGE_IDX : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)       w_state_nxt = STREAM;
            STREAM:  if (w_last_pix)  w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_end) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_drain <= '0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_addr <= base_addr;
                r_row  <= '0;
                r_col  <= '0;
            end
        end else if (r_state == STREAM) begin
            r_drain <= '0;
            if (!w_last_pix) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                if (r_col == LAST_IDX) begin
                    r_col <= '0;
                    r_row <= r_row + CW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end else begin
            r_drain <= r_drain + 3'd1;
        end
    end

    // Read data returns one cycle after the strobe and is registered onto next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_d1   <= 1'b0;
            r_shift_n <= 1'b1;
            r_next    <= '0;
        end else begin
            r_rd_d1   <= w_reading;
            r_shift_n <= !r_rd_d1;
            if (r_rd_d1) begin
                r_next <= mem_data;
            end
        end
    end

    win_delay_pipe #(
        .COORD_W (CW),
        .DEPTH   (PIPE_DEPTH)
    ) u_win_delay_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_in_valid),
        .i_row   (w_in_row),
        .i_col   (w_in_col),
        .o_valid (win_valid),
        .o_row   (win_row),
        .o_col   (win_col)
    );

    assign mem_rd     = w_reading;
    assign mem_addr   = r_addr;
    assign next       = r_next;
    assign shift_en_n = r_shift_n;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DRAIN) && w_drain_end;

endmodule

// File: tb/tb_conv_streamer.sv
// Directed bench: a 32x32 instance with a behavioural 5x5 window engine and golden sums,
// plus a 5x5 instance for the single-window corner.
module tb_conv_streamer;

    localparam int unsigned MS      = 32;
    localparam int unsigned ML      = 1;
    localparam int unsigned MS5     = 5;
    localparam int unsigned ML5     = 2;
    localparam int unsigned CW      = $clog2(MS);
    localparam int unsigned CW5     = $clog2(MS5);
    localparam int unsigned BUF_LEN = 4 * MS + 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [15:0]   base_addr = '0;
    logic          mem_rd;
    logic [15:0]   mem_addr;
    logic [7:0]    mem_data = '0;
    logic [7:0]    next;
    logic          shift_en_n, win_valid, busy, done;
    logic [CW-1:0] win_row, win_col;

    logic           start5 = 1'b0;
    logic [15:0]    base5 = '0;
    logic           mem_rd5;
    logic [15:0]    mem_addr5;
    logic [7:0]     mem_data5 = '0;
    logic [7:0]     next5;
    logic           shift_en_n5, win_valid5, busy5, done5;
    logic [CW5-1:0] win_row5, win_col5;

    conv_streamer #(
        .BIT_WIDTH (8), .MAP_SIZE (MS), .ADDR_WIDTH (16), .MULT_LAT (ML)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .base_addr (base_addr),
        .mem_rd (mem_rd), .mem_addr (mem_addr), .mem_data (mem_data), .next (next),
        .shift_en_n (shift_en_n), .win_valid (win_valid), .win_row (win_row),
        .win_col (win_col), .busy (busy), .done (done)
    );

    conv_streamer #(
        .BIT_WIDTH (8), .MAP_SIZE (MS5), .ADDR_WIDTH (16), .MULT_LAT (ML5)
    ) dut5 (
        .clk (clk), .rst (rst), .start (start5), .base_addr (base5),
        .mem_rd (mem_rd5), .mem_addr (mem_addr5), .mem_data (mem_data5), .next (next5),
        .shift_en_n (shift_en_n5), .win_valid (win_valid5), .win_row (win_row5),
        .win_col (win_col5), .busy (busy5), .done (done5)
    );

    // Memory returns the low address byte one cycle after the request.
    always @(posedge clk) begin
        mem_data  <= mem_addr[7:0];
        mem_data5 <= mem_addr5[7:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0, n_fail = 0;
    int          t0 = 0, t05 = 0;
    logic        clr = 1'b1;
    logic [15:0] cur_base = '0;

    // Behavioural window engine: raster line buffer, one register stage of sum.
    logic [7:0] eng_buf [BUF_LEN];
    int         eng_sum = 0;
    int         win_acc;
    always_comb begin
        win_acc = 0;
        for (int a = 0; a < 5; a++)
            for (int b = 0; b < 5; b++)
                win_acc += int'(eng_buf[a * int'(MS) + b]);
    end
    always @(posedge clk) begin
        if (!shift_en_n) begin
            for (int k = int'(BUF_LEN) - 1; k > 0; k--) eng_buf[k] <= eng_buf[k-1];
            eng_buf[0] <= next;
        end
        eng_sum <= win_acc;
    end

    function automatic int gsum(input logic [15:0] b, input int r, input int c);
        int s;
        logic [15:0] a;
        s = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                a = b + 16'((r + i) * int'(MS) + c + j);
                s += int'(a[7:0]);
            end
        return s;
    endfunction

    int rel, rel5;
    always_comb rel  = cyc + 1 - t0;
    always_comb rel5 = cyc + 1 - t05;

    int          rd_cnt, addr_err, win_cnt, win_first_rel, win_last_rel;
    int          first_row, first_col, last_row, last_col, coord_err, conv_err;
    int          done_cnt, done_rel, busy_cnt, busy_first, busy_last, shift_cnt;
    int          exp_r, exp_c;
    logic [15:0] rd_first, rd_last, exp_addr;

    always @(negedge clk) begin
        if (clr) begin
            rd_cnt <= 0; addr_err <= 0; win_cnt <= 0; win_first_rel <= 0; win_last_rel <= 0;
            first_row <= -1; first_col <= -1; last_row <= -1; last_col <= -1;
            coord_err <= 0; conv_err <= 0; done_cnt <= 0; done_rel <= 0;
            busy_cnt <= 0; busy_first <= 0; busy_last <= 0; shift_cnt <= 0;
            exp_r <= 0; exp_c <= 0; rd_first <= '0; rd_last <= '0; exp_addr <= cur_base;
        end else begin
            if (mem_rd) begin
                rd_cnt <= rd_cnt + 1;
                if (rd_cnt == 0) rd_first <= mem_addr;
                rd_last <= mem_addr;
                if (mem_addr !== exp_addr) addr_err <= addr_err + 1;
                exp_addr <= exp_addr + 16'd1;
            end
            if (win_valid) begin
                win_cnt <= win_cnt + 1;
                if (win_cnt == 0) begin
                    win_first_rel <= rel;
                    first_row <= int'(win_row);
                    first_col <= int'(win_col);
                end
                win_last_rel <= rel;
                last_row <= int'(win_row);
                last_col <= int'(win_col);
                if (int'(win_row) != exp_r || int'(win_col) != exp_c) coord_err <= coord_err + 1;
                if (eng_sum != gsum(cur_base, exp_r, exp_c)) conv_err <= conv_err + 1;
                if (exp_c == int'(MS) - 5) begin
                    exp_c <= 0;
                    exp_r <= exp_r + 1;
                end else begin
                    exp_c <= exp_c + 1;
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_rel <= rel;
            end
            if (busy) begin
                busy_cnt <= busy_cnt + 1;
                if (busy_cnt == 0) busy_first <= rel;
                busy_last <= rel;
            end
            if (!shift_en_n) shift_cnt <= shift_cnt + 1;
        end
    end

    int         win5_cnt, win5_rel, win5_row, win5_col, shift5_cnt, rd5_cnt, done5_rel;
    logic [7:0] next5_last;
    always @(negedge clk) begin
        if (clr) begin
            win5_cnt <= 0; win5_rel <= 0; win5_row <= -1; win5_col <= -1;
            shift5_cnt <= 0; rd5_cnt <= 0; done5_rel <= 0; next5_last <= '0;
        end else begin
            if (win_valid5) begin
                win5_cnt <= win5_cnt + 1;
                win5_rel <= rel5;
                win5_row <= int'(win_row5);
                win5_col <= int'(win_col5);
            end
            if (!shift_en_n5) begin
                shift5_cnt <= shift5_cnt + 1;
                next5_last <= next5;
            end
            if (mem_rd5) rd5_cnt <= rd5_cnt + 1;
            if (done5) done5_rel <= rel5;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_next"}, 32'(next), 32'd0);
        check({tag, "_shift_en_n"}, 32'(shift_en_n), 32'd1);
        check({tag, "_win_valid"}, 32'(win_valid), 32'd0);
        check({tag, "_win_row"}, 32'(win_row), 32'd0);
        check({tag, "_win_col"}, 32'(win_col), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Called just after an edge; the following edge is T0.
    task automatic launch(input logic [15:0] b);
        base_addr = b;
        cur_base  = b;
        start     = 1'b1;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = done;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    // 32x32, MULT_LAT=1: windows at T0+137..T0+1028, done at T0+1029.
    task automatic check_map(input logic [15:0] b);
        check("rd_cnt", rd_cnt, 1024);
        check("rd_first", 32'(rd_first), 32'(b));
        check("rd_last", 32'(rd_last), 32'(16'(b + 16'd1023)));
        check("addr_err", addr_err, 0);
        check("win_cnt", win_cnt, 784);
        check("win_first_rel", win_first_rel, 137);
        check("first_row", first_row, 0);
        check("first_col", first_col, 0);
        check("win_last_rel", win_last_rel, 1028);
        check("last_row", last_row, 27);
        check("last_col", last_col, 27);
        check("coord_err", coord_err, 0);
        check("conv_err", conv_err, 0);
        check("done_cnt", done_cnt, 1);
        check("done_rel", done_rel, 1029);
        check("busy_first", busy_first, 1);
        check("busy_last", busy_last, 1029);
        check("busy_cnt", busy_cnt, 1029);
        check("shift_cnt", shift_cnt, 1024);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Map A with a stray start mid-stream.
        launch(16'h0100);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1100);

        // Start held through the done cycle is ignored, accepted one cycle later.
        start     = 1'b1;
        base_addr = 16'h2000;
        @(negedge clk);
        #1;
        check_map(16'h0100);
        cur_base = 16'h2000;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_done_busy", 32'(busy), 32'd0);
        check("idle_after_done_rd", 32'(mem_rd), 32'd0);
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        clr   = 1'b0;
        wait_done(1100);
        @(negedge clk);
        #1;
        check_map(16'h2000);

        // Abort mid-stream with reset, then confirm nothing runs without a new start.
        @(posedge clk);
        #1;
        launch(16'h0100);
        repeat (499) @(posedge clk);
        #1;
        check("pre_abort_rd", 32'(mem_rd), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
        repeat (1100) @(posedge clk);
        #1;
        check("post_abort_rd", rd_cnt, 0);
        check("post_abort_win", win_cnt, 0);
        check("post_abort_done", done_cnt, 0);
        check("post_abort_busy", busy_cnt, 0);

        launch(16'h0100);
        wait_done(1100);
        @(negedge clk);
        #1;
        check_map(16'h0100);

        // Address wrap through 0xFFFF.
        @(posedge clk);
        #1;
        launch(16'hFF80);
        wait_done(1100);
        @(negedge clk);
        #1;
        check_map(16'hFF80);

        // 5x5 map: one window, last pixel p=24 -> T0+4+24+2.
        @(posedge clk);
        #1;
        base5 = 16'h0040;
        start5 = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        t05 = cyc;
        start5 = 1'b0;
        clr = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("m5_win_cnt", win5_cnt, 1);
        check("m5_win_rel", win5_rel, 30);
        check("m5_win_row", win5_row, 0);
        check("m5_win_col", win5_col, 0);
        check("m5_shift_cnt", shift5_cnt, 25);
        check("m5_rd_cnt", rd5_cnt, 25);
        check("m5_next_last", 32'(next5_last), 32'h58);
        check("m5_done_rel", done5_rel, 31);
        check("m5_busy_end", 32'(busy5), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
